// File: rtl/prf_wb_arb_regfile_pkg.sv
// Shared types and constants for the RCU physical register file.
//   preg_t     physical register index
//   xlen_t     architectural data word
//   WB_*       writeback source numbering (position in the wb_* port vectors)
//   wr_port_t  one array write port after arbitration
//   preg_in_range  bounds check for a preg index against the file depth
package prf_pkg;

    localparam int PRF_REG_SIZE       = 64;
    localparam int PRF_REG_SIZE_WIDTH = 6;
    localparam int PRF_XLEN           = 64;

    typedef logic [PRF_REG_SIZE_WIDTH-1:0] preg_t;
    typedef logic [PRF_XLEN-1:0]           xlen_t;

    localparam int WB_ALU1  = 0;
    localparam int WB_ALU2  = 1;
    localparam int WB_FALU1 = 2;
    localparam int WB_FALU2 = 3;
    localparam int WB_LSU   = 4;
    localparam int WB_MD    = 5;

    typedef struct packed {
        logic  valid;
        preg_t addr;
        xlen_t data;
    } wr_port_t;

    // True when the index addresses an implemented register.
    function automatic logic preg_in_range(input preg_t a, input int unsigned size);
        int unsigned ai;
        ai = 32'(a);
        return (ai < size);
    endfunction

endpackage

// File: rtl/prf_wb_arb_regfile_arb.sv
// Round-robin writeback arbiter.
// Scans the request vector starting at rr_ptr and grants up to NUM_WR
// requesters; the k-th granted source is steered to write port k.
//   clk, rst   clock, synchronous active-high reset (clears rr_ptr, masks grants)
//   req        one request bit per writeback source
//   grant      one grant bit per source (the source's ready)
//   port_vld   write port k carries a granted request
//   port_src   source index driving write port k
module wb_rr_arbiter #(
    parameter int NUM_WB = 6,
    parameter int NUM_WR = 2,
    parameter int SRC_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WB-1:0]            req,
    output logic [NUM_WB-1:0]            grant,
    output logic [NUM_WR-1:0]            port_vld,
    output logic [NUM_WR-1:0][SRC_W-1:0] port_src
);

    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] rr_ptr_d;

    // rank counts how many requesters were already granted ahead of the
    // current scan position; it selects the write port for the next grant.
    always_comb begin
        int               rank;
        logic [SRC_W-1:0] src;
        rank     = 0;
        src      = '0;
        grant    = '0;
        port_vld = '0;
        port_src = '0;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NUM_WB; i++) begin
            src = SRC_W'((int'(rr_ptr_q) + i) % NUM_WB);
            if (req[src] && !rst) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (rank == k) begin
                        grant[src]  = 1'b1;
                        port_vld[k] = 1'b1;
                        port_src[k] = src;
                        // Last grant in scan order decides where the next scan starts.
                        rr_ptr_d    = SRC_W'((int'(src) + 1) % NUM_WB);
                    end
                end
                rank++;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/prf_wb_arb_regfile.sv
// Physical register file with arbitrated writeback and a per-register ready table.
//   clk, rst       clock, synchronous active-high reset
//   wb_valid_i     writeback request per source
//   wb_addr_i      destination preg per source (packed, source 0 in the LSBs)
//   wb_data_i      writeback data per source
//   wb_ready_o     grant per source; a transfer happens on valid & ready
//   rd_addr_i      read address per read port
//   rd_data_o      combinational read data per port
//   rd_rdy_o       ready bit of the addressed preg per port
//   alloc_valid_i  rename allocation per alloc port
//   alloc_addr_i   allocated preg; its ready bit is cleared
// P0 reads as zero and is always ready; writes to it are granted but dropped.
module prf_wb_arb_regfile
    import prf_pkg::*;
#(
    parameter int REG_SIZE       = 64,
    parameter int REG_SIZE_WIDTH = 6,
    parameter int XLEN           = 64,
    parameter int NUM_WB         = 6,
    parameter int NUM_WR         = 2,
    parameter int NUM_RD         = 6,
    parameter int NUM_ALLOC      = 2,
    parameter bit BYPASS_EN      = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_WB-1:0]                   wb_valid_i,
    input  logic [NUM_WB*REG_SIZE_WIDTH-1:0]    wb_addr_i,
    input  logic [NUM_WB*XLEN-1:0]              wb_data_i,
    output logic [NUM_WB-1:0]                   wb_ready_o,
    input  logic [NUM_RD*REG_SIZE_WIDTH-1:0]    rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]              rd_data_o,
    output logic [NUM_RD-1:0]                   rd_rdy_o,
    input  logic [NUM_ALLOC-1:0]                alloc_valid_i,
    input  logic [NUM_ALLOC*REG_SIZE_WIDTH-1:0] alloc_addr_i
);

    localparam int SRC_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    // The package types fix the address and data widths of the write ports.
    if (REG_SIZE_WIDTH != $bits(preg_t) || XLEN != $bits(xlen_t)) begin : g_bad_width
        $error("prf_wb_arb_regfile: REG_SIZE_WIDTH/XLEN must match prf_pkg types");
    end
    if (NUM_WR < 1 || NUM_WR > NUM_WB) begin : g_bad_ports
        $error("prf_wb_arb_regfile: NUM_WR must lie in 1..NUM_WB");
    end

    preg_t [NUM_WB-1:0]    wb_addr;
    xlen_t [NUM_WB-1:0]    wb_data;
    preg_t [NUM_RD-1:0]    rd_addr;
    xlen_t [NUM_RD-1:0]    rd_data;
    logic  [NUM_RD-1:0]    rd_rdy;
    preg_t [NUM_ALLOC-1:0] alloc_addr;

    assign wb_addr    = wb_addr_i;
    assign wb_data    = wb_data_i;
    assign rd_addr    = rd_addr_i;
    assign alloc_addr = alloc_addr_i;
    assign rd_data_o  = rd_data;
    assign rd_rdy_o   = rd_rdy;

    xlen_t               mem [REG_SIZE];
    logic [REG_SIZE-1:0] rdy_q;

    logic [NUM_WB-1:0]            grant;
    logic [NUM_WR-1:0]            port_vld;
    logic [NUM_WR-1:0][SRC_W-1:0] port_src;
    wr_port_t [NUM_WR-1:0]        wr;

    wb_rr_arbiter #(
        .NUM_WB (NUM_WB),
        .NUM_WR (NUM_WR),
        .SRC_W  (SRC_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (wb_valid_i),
        .grant    (grant),
        .port_vld (port_vld),
        .port_src (port_src)
    );

    // Grants are already masked during reset inside the arbiter.
    assign wb_ready_o = grant;

    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wr[k].valid = port_vld[k];
            wr[k].addr  = wb_addr[port_src[k]];
            wr[k].data  = wb_data[port_src[k]];
        end
    end

    // Array and ready table. Later loop iterations override earlier ones, so
    // the higher-numbered write port wins a same-address collision and an
    // allocation clear beats a same-cycle writeback set: a writeback that
    // lands as its preg is being re-allocated belongs to the old mapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_SIZE; r++) begin
                mem[r] <= '0;
            end
            rdy_q <= '1;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr[k].valid && wr[k].addr != '0 && preg_in_range(wr[k].addr, REG_SIZE)) begin
                    mem[wr[k].addr]   <= wr[k].data;
                    rdy_q[wr[k].addr] <= 1'b1;
                end
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_valid_i[a] && alloc_addr[a] != '0 && preg_in_range(alloc_addr[a], REG_SIZE)) begin
                    rdy_q[alloc_addr[a]] <= 1'b0;
                end
            end
        end
    end

    // Read ports with optional forwarding of this cycle's granted writes.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = '0;
            rd_rdy[p]  = 1'b0;
            if (rd_addr[p] == '0) begin
                rd_rdy[p] = 1'b1;
            end else if (preg_in_range(rd_addr[p], REG_SIZE)) begin
                rd_data[p] = mem[rd_addr[p]];
                rd_rdy[p]  = rdy_q[rd_addr[p]];
                if (BYPASS_EN) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr[k].valid && wr[k].addr == rd_addr[p]) begin
                            rd_data[p] = wr[k].data;
                            rd_rdy[p]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Protocol checks on the rename/writeback contract.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr[k].valid) begin
                    assert (preg_in_range(wr[k].addr, REG_SIZE))
                        else $error("prf: writeback to out-of-range preg %0d", wr[k].addr);
                end
                for (int j = k + 1; j < NUM_WR; j++) begin
                    if (wr[k].valid && wr[j].valid && wr[k].addr != '0) begin
                        assert (wr[k].addr != wr[j].addr)
                            else $error("prf: two writes to preg %0d in one cycle", wr[k].addr);
                    end
                end
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_valid_i[a]) begin
                    assert (preg_in_range(alloc_addr[a], REG_SIZE))
                        else $error("prf: allocation of out-of-range preg %0d", alloc_addr[a]);
                end
            end
        end
    end

endmodule

// File: tb/tb_prf_wb_arb_regfile.sv
module tb_prf_wb_arb_regfile;
    import prf_pkg::*;

    logic         clk;
    logic         rst;
    logic [5:0]   wb_valid_i;
    logic [35:0]  wb_addr_i;
    logic [383:0] wb_data_i;
    logic [5:0]   wb_ready_o;
    logic [35:0]  rd_addr_i;
    logic [383:0] rd_data_o;
    logic [5:0]   rd_rdy_o;
    logic [1:0]   alloc_valid_i;
    logic [11:0]  alloc_addr_i;

    int n_vec;
    int n_miss;

    prf_wb_arb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .wb_ready_o    (wb_ready_o),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .rd_rdy_o      (rd_rdy_o),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_inputs();
        wb_valid_i    = '0;
        wb_addr_i     = '0;
        wb_data_i     = '0;
        rd_addr_i     = '0;
        alloc_valid_i = '0;
        alloc_addr_i  = '0;
    endtask

    task automatic put_wb(input int s, input logic [5:0] a, input logic [63:0] d);
        wb_valid_i[s]         = 1'b1;
        wb_addr_i[s*6 +: 6]   = a;
        wb_data_i[s*64 +: 64] = d;
    endtask

    task automatic put_rd(input int p, input logic [5:0] a);
        rd_addr_i[p*6 +: 6] = a;
    endtask

    function automatic logic [63:0] rdd(input int p);
        return rd_data_o[p*64 +: 64];
    endfunction

    // Reset state: no grants while rst is high, all pregs zero and ready.
    task automatic test_reset();
        rst = 1'b1;
        clr_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 6; s++) put_wb(s, 6'(10 + s), 64'hBAD0 + 64'(s));
        #1;
        n_vec++;
        if (wb_ready_o !== 6'b000000) begin
            n_miss++;
            $display("FAIL reset_ready: got %b want 000000", wb_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_valid_i = '0;
        for (int p = 0; p < 6; p++) put_rd(p, 6'd5);
        #1;
        for (int p = 0; p < 6; p++) begin
            n_vec++;
            if (rdd(p) !== 64'h0) begin
                n_miss++;
                $display("FAIL reset_data port%0d: got %h want 0", p, rdd(p));
            end
            n_vec++;
            if (rd_rdy_o[p] !== 1'b1) begin
                n_miss++;
                $display("FAIL reset_rdy port%0d: got %b want 1", p, rd_rdy_o[p]);
            end
        end
        put_rd(0, 6'd10);
        #1;
        n_vec++;
        if (rdd(0) !== 64'h0) begin
            n_miss++;
            $display("FAIL reset_nowrite P10: got %h want 0", rdd(0));
        end
    endtask

    // Allocation clears ready; a writeback bypasses then lands in the array.
    task automatic test_alloc_wb();
        @(negedge clk);
        alloc_valid_i[0]  = 1'b1;
        alloc_addr_i[5:0] = 6'd7;
        put_rd(0, 6'd7);
        @(negedge clk);
        alloc_valid_i = '0;
        #1;
        n_vec++;
        if (rd_rdy_o[0] !== 1'b0) begin
            n_miss++;
            $display("FAIL alloc_clear P7 rdy: got %b want 0", rd_rdy_o[0]);
        end
        put_wb(WB_ALU1, 6'd7, 64'hDEAD);
        #1;
        n_vec++;
        if (wb_ready_o !== 6'b000001) begin
            n_miss++;
            $display("FAIL alu1_grant: got %b want 000001", wb_ready_o);
        end
        n_vec++;
        if (rdd(0) !== 64'hDEAD || rd_rdy_o[0] !== 1'b1) begin
            n_miss++;
            $display("FAIL bypass P7: got %h/%b want dead/1", rdd(0), rd_rdy_o[0]);
        end
        @(negedge clk);
        wb_valid_i = '0;
        #1;
        n_vec++;
        if (rdd(0) !== 64'hDEAD || rd_rdy_o[0] !== 1'b1) begin
            n_miss++;
            $display("FAIL array P7: got %h/%b want dead/1", rdd(0), rd_rdy_o[0]);
        end
    endtask

    // A write to P0 is granted but never changes P0.
    task automatic test_p0_write();
        @(negedge clk);
        put_wb(WB_LSU, 6'd0, 64'hFFFF);
        put_rd(0, 6'd0);
        #1;
        n_vec++;
        if (wb_ready_o !== 6'b010000) begin
            n_miss++;
            $display("FAIL p0_grant: got %b want 010000", wb_ready_o);
        end
        n_vec++;
        if (rdd(0) !== 64'h0 || rd_rdy_o[0] !== 1'b1) begin
            n_miss++;
            $display("FAIL p0_bypass: got %h/%b want 0/1", rdd(0), rd_rdy_o[0]);
        end
        @(negedge clk);
        wb_valid_i = '0;
        #1;
        n_vec++;
        if (rdd(0) !== 64'h0 || rd_rdy_o[0] !== 1'b1) begin
            n_miss++;
            $display("FAIL p0_array: got %h/%b want 0/1", rdd(0), rd_rdy_o[0]);
        end
    endtask

    // Alloc and writeback of the same preg in one cycle: data lands, ready stays clear.
    task automatic test_alloc_same_cycle();
        @(negedge clk);
        alloc_valid_i[1]   = 1'b1;
        alloc_addr_i[11:6] = 6'd9;
        put_wb(WB_MD, 6'd9, 64'h1234);
        put_rd(1, 6'd9);
        #1;
        n_vec++;
        if (wb_ready_o !== 6'b100000) begin
            n_miss++;
            $display("FAIL md_grant: got %b want 100000", wb_ready_o);
        end
        @(negedge clk);
        alloc_valid_i = '0;
        wb_valid_i    = '0;
        #1;
        n_vec++;
        if (rdd(1) !== 64'h1234 || rd_rdy_o[1] !== 1'b0) begin
            n_miss++;
            $display("FAIL clear_wins P9: got %h/%b want 1234/0", rdd(1), rd_rdy_o[1]);
        end
        @(negedge clk);
        put_wb(WB_MD, 6'd9, 64'h5678);
        #1;
        n_vec++;
        if (rdd(1) !== 64'h5678 || rd_rdy_o[1] !== 1'b1) begin
            n_miss++;
            $display("FAIL bypass P9: got %h/%b want 5678/1", rdd(1), rd_rdy_o[1]);
        end
        @(negedge clk);
        wb_valid_i = '0;
        #1;
        n_vec++;
        if (rdd(1) !== 64'h5678 || rd_rdy_o[1] !== 1'b1) begin
            n_miss++;
            $display("FAIL later_write P9: got %h/%b want 5678/1", rdd(1), rd_rdy_o[1]);
        end
    endtask

    // All sources valid from rr_ptr = 0; data bumps each time a source is granted.
    task automatic test_round_robin();
        logic [5:0] exp_g [4];
        int         ngr [6];
        int         once [6];
        logic [5:0] g;
        exp_g[0] = 6'b000011;
        exp_g[1] = 6'b001100;
        exp_g[2] = 6'b110000;
        exp_g[3] = 6'b000011;
        for (int s = 0; s < 6; s++) begin
            ngr[s]  = 0;
            once[s] = 0;
        end
        @(negedge clk);
        for (int s = 0; s < 6; s++) put_wb(s, 6'(20 + s), 64'((s + 1) * 256));
        for (int n = 0; n < 4; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            g = wb_ready_o;
            n_vec++;
            if (g !== exp_g[n]) begin
                n_miss++;
                $display("FAIL rr_grant cycle%0d: got %b want %b", n, g, exp_g[n]);
            end
            @(posedge clk);
            #1;
            for (int s = 0; s < 6; s++) begin
                if (g[s] === 1'b1) begin
                    ngr[s]++;
                    if (n < 3) once[s]++;
                    put_wb(s, 6'(20 + s), 64'((s + 1) * 256 + ngr[s]));
                end
            end
        end
        for (int s = 0; s < 6; s++) begin
            n_vec++;
            if (once[s] !== 1) begin
                n_miss++;
                $display("FAIL rr_fair src%0d: got %0d grants in 3 cycles want 1", s, once[s]);
            end
        end
        @(negedge clk);
        wb_valid_i = '0;
        for (int p = 0; p < 6; p++) put_rd(p, 6'(20 + p));
        #1;
        for (int p = 0; p < 6; p++) begin
            n_vec++;
            if (rdd(p) !== 64'((p + 1) * 256 + ((p < 2) ? 1 : 0)) || rd_rdy_o[p] !== 1'b1) begin
                n_miss++;
                $display("FAIL rr_data P%0d: got %h/%b want %h/1", 20 + p, rdd(p), rd_rdy_o[p],
                         64'((p + 1) * 256 + ((p < 2) ? 1 : 0)));
            end
        end
    endtask

    // Reset with requests pending and rr_ptr = 4 abandons them and restarts at source 0.
    task automatic test_reset_mid();
        @(negedge clk);
        put_wb(WB_FALU2, 6'd40, 64'h77);
        #1;
        n_vec++;
        if (wb_ready_o !== 6'b001000) begin
            n_miss++;
            $display("FAIL pre_reset_grant: got %b want 001000", wb_ready_o);
        end
        @(negedge clk);
        wb_valid_i = '0;
        for (int s = 0; s < 3; s++) put_wb(s, 6'(30 + s), 64'hAA00 + 64'(s));
        rst = 1'b1;
        #1;
        n_vec++;
        if (wb_ready_o !== 6'b000000) begin
            n_miss++;
            $display("FAIL mid_reset_ready: got %b want 000000", wb_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_valid_i = '0;
        put_rd(0, 6'd30);
        put_rd(1, 6'd31);
        put_rd(2, 6'd32);
        put_rd(3, 6'd40);
        put_rd(4, 6'd7);
        put_rd(5, 6'd9);
        #1;
        for (int p = 0; p < 6; p++) begin
            n_vec++;
            if (rdd(p) !== 64'h0 || rd_rdy_o[p] !== 1'b1) begin
                n_miss++;
                $display("FAIL mid_reset_state port%0d: got %h/%b want 0/1", p, rdd(p), rd_rdy_o[p]);
            end
        end
        @(negedge clk);
        for (int s = 0; s < 6; s++) put_wb(s, 6'(50 + s), 64'h5000 + 64'(s));
        #1;
        n_vec++;
        if (wb_ready_o !== 6'b000011) begin
            n_miss++;
            $display("FAIL ptr_after_reset: got %b want 000011", wb_ready_o);
        end
        @(negedge clk);
        wb_valid_i = '0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_alloc_wb();
        test_p0_write();
        test_alloc_same_cycle();
        test_round_robin();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
